// File: rtl/out_n_clock_prog.sv
// rtl/out_n_clock_prog.sv - programmable one-in-N pulse generator; OUT_N_CLOCK_PROG_PW_EN adds a programmable pulse width
module out_n_clock_prog #(
    parameter int WIDTH     = 8,
    parameter int DEFAULT_N = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] n_in,
    input  logic             oneshot,
`ifdef OUT_N_CLOCK_PROG_PW_EN
    input  logic [WIDTH-1:0] pw,
`endif
    output logic             out,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    typedef enum logic [1:0] {
        RUN,
        STRETCH,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] per;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] last;

    // per=0 is treated as a period of one, so the terminal count is 0 either way
    assign last  = (per == '0) ? '0 : per - 1'b1;
    assign count = cnt;

`ifdef OUT_N_CLOCK_PROG_PW_EN
    logic [WIDTH-1:0] pwr;
    logic [WIDTH-1:0] wcnt;
    logic [WIDTH-1:0] p_eff;
    logic [WIDTH-1:0] pw_eff;
    logic [WIDTH-1:0] w;

    assign p_eff  = (per == '0) ? WIDTH'(1) : per;
    assign pw_eff = (pwr == '0) ? WIDTH'(1) : pwr;
    // a stretched pulse never outlasts its period
    assign w      = (pw_eff < p_eff) ? pw_eff : p_eff;
`endif

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= RUN;
            per   <= WIDTH'(DEFAULT_N);
            cnt   <= '0;
            out   <= 1'b0;
            done  <= 1'b0;
`ifdef OUT_N_CLOCK_PROG_PW_EN
            pwr   <= WIDTH'(1);
            wcnt  <= '0;
`endif
        end else if (load) begin
            state <= RUN;
            per   <= n_in;
            cnt   <= '0;
            out   <= 1'b0;
            done  <= 1'b0;
`ifdef OUT_N_CLOCK_PROG_PW_EN
            pwr   <= pw;
            wcnt  <= '0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        if (cnt == last) begin
                            cnt <= '0;
                            out <= 1'b1;
`ifdef OUT_N_CLOCK_PROG_PW_EN
                            wcnt <= WIDTH'(1);
                            if (oneshot) begin
                                if (w == WIDTH'(1)) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= STRETCH;
                                end
                            end
`else
                            if (oneshot) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
`ifdef OUT_N_CLOCK_PROG_PW_EN
                            if (out) begin
                                if (wcnt >= w) begin
                                    out <= 1'b0;
                                end else begin
                                    wcnt <= wcnt + 1'b1;
                                end
                            end
`else
                            out <= 1'b0;
`endif
                        end
                    end else begin
`ifndef OUT_N_CLOCK_PROG_PW_EN
                        out <= 1'b0;
`endif
                    end
                end
`ifdef OUT_N_CLOCK_PROG_PW_EN
                // one-shot pulse still stretching; DONE follows once it ends
                STRETCH: begin
                    cnt <= '0;
                    if (enable) begin
                        if (wcnt >= w) begin
                            out   <= 1'b0;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    out <= 1'b0;
                    cnt <= '0;
`ifdef OUT_N_CLOCK_PROG_PW_EN
                    wcnt <= '0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_n_clock_prog.sv
// tb/tb_out_n_clock_prog.sv - directed scoreboard bench for out_n_clock_prog
module tb_out_n_clock_prog;

    logic       clock = 1'b0;
    logic       reset_;
    logic       enable;
    logic       load;
    logic [7:0] n_in;
    logic       oneshot;
`ifdef OUT_N_CLOCK_PROG_PW_EN
    logic [7:0] pw;
`endif
    logic       out;
    logic [7:0] count;
    logic       done;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic       q_out[$];
    logic [7:0] q_cnt[$];
    logic       q_done[$];
    string      q_tag[$];

    out_n_clock_prog #(
        .WIDTH    (8),
        .DEFAULT_N(4)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .enable (enable),
        .load   (load),
        .n_in   (n_in),
        .oneshot(oneshot),
`ifdef OUT_N_CLOCK_PROG_PW_EN
        .pw     (pw),
`endif
        .out    (out),
        .count  (count),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic expect_next(input string tag, input logic eo, input logic [7:0] ec, input logic ed);
        q_tag.push_back(tag);
        q_out.push_back(eo);
        q_cnt.push_back(ec);
        q_done.push_back(ed);
    endtask

    task automatic compare_head();
        string      t;
        logic       eo;
        logic [7:0] ec;
        logic       ed;
        t  = q_tag.pop_front();
        eo = q_out.pop_front();
        ec = q_cnt.pop_front();
        ed = q_done.pop_front();
        checks++;
        assert (out === eo) passed = passed + 1;
        else begin
            fails++;
            $error("FAIL %s out observed=%b expected=%b", t, out, eo);
        end
        checks++;
        assert (count === ec) passed = passed + 1;
        else begin
            fails++;
            $error("FAIL %s count observed=%0d expected=%0d", t, count, ec);
        end
        checks++;
        assert (done === ed) passed = passed + 1;
        else begin
            fails++;
            $error("FAIL %s done observed=%b expected=%b", t, done, ed);
        end
    endtask

    task automatic cyc(input string tag, input logic eo, input logic [7:0] ec, input logic ed);
        expect_next(tag, eo, ec, ed);
        @(posedge clock);
        #1;
        compare_head();
    endtask

    task automatic check_now(input string tag, input logic eo, input logic [7:0] ec, input logic ed);
        expect_next(tag, eo, ec, ed);
        compare_head();
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        reset_  = 1'b0;
        load    = 1'b0;
        enable  = 1'b0;
        oneshot = 1'b0;
        #1;
        check_now("reset", 1'b0, 8'd0, 1'b0);
        @(posedge clock);
        #1;
        reset_ = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_  = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        oneshot = 1'b0;
        n_in    = 8'd0;
`ifdef OUT_N_CLOCK_PROG_PW_EN
        pw      = 8'd1;
`endif

        // default period free-running
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 15; k++)
            cyc($sformatf("free_k%0d", k), (k % 4) == 0, 8'(k % 4), 1'b0);

        // reload to 3 at cycle 6
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 5; k++)
            cyc($sformatf("pre_load_k%0d", k), (k % 4) == 0, 8'(k % 4), 1'b0);
        load = 1'b1;
        n_in = 8'd3;
        cyc("load3", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 9; j++)
            cyc($sformatf("per3_j%0d", j), (j % 3) == 0, 8'(j % 3), 1'b0);

        // period 0 and 1 both pulse every enabled cycle
        load = 1'b1;
        n_in = 8'd0;
        cyc("load0", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 5; j++)
            cyc($sformatf("per0_j%0d", j), 1'b1, 8'd0, 1'b0);
        load = 1'b1;
        n_in = 8'd1;
        cyc("load1", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 5; j++)
            cyc($sformatf("per1_j%0d", j), 1'b1, 8'd0, 1'b0);

        // pause at count 2, then resume without losing phase
        do_reset();
        enable = 1'b1;
        cyc("run1", 1'b0, 8'd1, 1'b0);
        cyc("run2", 1'b0, 8'd2, 1'b0);
        enable = 1'b0;
        for (int j = 1; j <= 5; j++)
            cyc($sformatf("pause_j%0d", j), 1'b0, 8'd2, 1'b0);
        enable = 1'b1;
        cyc("resume3", 1'b0, 8'd3, 1'b0);
        cyc("resume_pulse", 1'b1, 8'd0, 1'b0);
        cyc("resume1", 1'b0, 8'd1, 1'b0);
        cyc("resume2", 1'b0, 8'd2, 1'b0);
        cyc("resume3b", 1'b0, 8'd3, 1'b0);
        load = 1'b1;
        n_in = 8'd4;
        cyc("load_beats_pulse", 1'b0, 8'd0, 1'b0);
        load = 1'b0;

        // one-shot of period 5, then reload leaves DONE
        oneshot = 1'b1;
        load    = 1'b1;
        n_in    = 8'd5;
        cyc("os_load5", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        for (int k = 1; k <= 4; k++)
            cyc($sformatf("os_k%0d", k), 1'b0, 8'(k), 1'b0);
        cyc("os_pulse", 1'b1, 8'd0, 1'b1);
        for (int j = 1; j <= 20; j++)
            cyc($sformatf("os_done_j%0d", j), 1'b0, 8'd0, 1'b1);
        oneshot = 1'b0;
        load    = 1'b1;
        n_in    = 8'd2;
        cyc("os_load2", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        cyc("p2_a", 1'b0, 8'd1, 1'b0);
        cyc("p2_b", 1'b1, 8'd0, 1'b0);
        cyc("p2_c", 1'b0, 8'd1, 1'b0);
        cyc("p2_d", 1'b1, 8'd0, 1'b0);

        // oneshot only matters at the pulse edge
        load = 1'b1;
        n_in = 8'd4;
        cyc("tog_load4", 1'b0, 8'd0, 1'b0);
        load    = 1'b0;
        oneshot = 1'b1;
        cyc("tog_1", 1'b0, 8'd1, 1'b0);
        oneshot = 1'b0;
        cyc("tog_2", 1'b0, 8'd2, 1'b0);
        cyc("tog_3", 1'b0, 8'd3, 1'b0);
        cyc("tog_pulse", 1'b1, 8'd0, 1'b0);
        cyc("tog_after", 1'b0, 8'd1, 1'b0);

        // asynchronous reset during a one-shot pulse
        load    = 1'b1;
        oneshot = 1'b1;
        n_in    = 8'd3;
        cyc("ar_load3", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        cyc("ar_1", 1'b0, 8'd1, 1'b0);
        cyc("ar_2", 1'b0, 8'd2, 1'b0);
        cyc("ar_pulse", 1'b1, 8'd0, 1'b1);
        #3;
        reset_ = 1'b0;
        #1;
        check_now("async_reset", 1'b0, 8'd0, 1'b0);
        @(posedge clock);
        #1;
        reset_  = 1'b1;
        oneshot = 1'b0;
        enable  = 1'b1;
        for (int k = 1; k <= 8; k++)
            cyc($sformatf("post_reset_k%0d", k), (k % 4) == 0, 8'(k % 4), 1'b0);

`ifdef OUT_N_CLOCK_PROG_PW_EN
        // stretched pulse of 3 in a period of 6
        pw   = 8'd3;
        load = 1'b1;
        n_in = 8'd6;
        cyc("pw3_load", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 18; j++)
            cyc($sformatf("pw3_j%0d", j), (j >= 6) && ((j % 6) < 3), 8'(j % 6), 1'b0);
        // width larger than the period clamps to the period
        pw   = 8'd9;
        load = 1'b1;
        n_in = 8'd6;
        cyc("pw9_load", 1'b0, 8'd0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 18; j++)
            cyc($sformatf("pw9_j%0d", j), j >= 6, 8'(j % 6), 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
